// File: rtl/count_window_scheduler.sv
// Round-robin arbiter that lends one event counter to NUM_REQ clients, one
// counting window per grant, and publishes each finished window's result.
module count_window_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [LEN_W-1:0]   window_len,
    input  logic               event_in,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [CNT_W-1:0]   count_out,
    output logic               overflow,
    output logic               done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, COUNT, REPORT} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   count_out_q, count_out_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   winner_q, winner_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   winner_next;
    logic [CNT_W:0]     inc;

    // Scanning downward lets the candidate closest to ptr overwrite the rest.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign winner_next = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
    assign inc         = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        count_out_d = count_out_q;
        overflow_d  = overflow_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    winner_d = pick_idx;
                    grant_d  = NUM_REQ'(1) << pick_idx;
                    busy_d   = 1'b1;
                    len_d    = window_len;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                if (!req[winner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = winner_next;
                end else begin
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    remaining_d = len_q;
                    if (len_q != '0) begin
                        state_d = COUNT;
                    end else begin
                        state_d     = REPORT;
                        count_out_d = '0;
                        overflow_d  = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            COUNT: begin
                if (!req[winner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = winner_next;
                end else begin
                    if (event_in) begin
                        cnt_d = inc[CNT_W-1:0];
                        ovf_d = ovf_q | inc[CNT_W];
                    end
                    remaining_d = remaining_q - LEN_W'(1);
                    // The last sample's event is already folded into cnt_d/ovf_d here.
                    if (remaining_q == LEN_W'(1)) begin
                        state_d     = REPORT;
                        count_out_d = cnt_d;
                        overflow_d  = ovf_d;
                        done_d      = 1'b1;
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = winner_next;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_out_q <= '0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            len_q       <= '0;
            remaining_q <= '0;
            ptr_q       <= '0;
            winner_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_out_q <= count_out_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count_out = count_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_window_scheduler.sv
// Directed and randomized windows against a transaction-level model of the
// shared counter: winner by rotation, result = event total mod 16.
module tb_count_window_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] window_len = '0;
    logic       event_in = 1'b0;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] count_out;
    logic       overflow;
    logic       done;

    int         checks = 0;
    int         errors = 0;
    int         ptrModel = 0;
    logic [3:0] lastCount = '0;
    logic       lastOvf = 1'b0;
    logic       evs [0:63];

    count_window_scheduler #(.NUM_REQ(4), .CNT_W(4), .LEN_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .window_len (window_len),
        .event_in   (event_in),
        .grant      (grant),
        .busy       (busy),
        .count_out  (count_out),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] wl, input logic ev);
        req        = r;
        window_len = wl;
        event_in   = ev;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int pickWinner(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            int idx = (ptrModel + i) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int w);
        logic [3:0] v = 4'b0001;
        return v << w;
    endfunction

    task automatic fillEvents(input int mode, input int len);
        for (int k = 0; k < 64; k++)
            evs[k] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    // lateLen < 0 scrambles window_len after the grant edge.
    task automatic runWindow(input logic [3:0] reqVal, input int len, input int lateLen, input bit keepReq);
        int         w;
        int         sum;
        logic [3:0] gexp;
        logic [3:0] expCount;
        logic       expOvf;
        logic [7:0] wl;
        w    = pickWinner(reqVal);
        gexp = onehot(w);
        sum  = 0;
        for (int k = 0; k < len; k++) sum += int'(evs[k]);
        expCount = 4'(sum % 16);
        expOvf   = (sum >= 16);

        applyStimulus(reqVal, 8'(len), 1'b0);
        tick();
        checkOutput("grant_at_grant_edge", grant, gexp);
        checkOutput("busy_at_grant_edge", busy, 1);
        checkOutput("done_low_in_clear", done, 0);

        wl = (lateLen >= 0) ? 8'(lateLen) : 8'($urandom_range(0, 255));
        applyStimulus(4'($urandom_range(0, 15)) | gexp, wl, 1'b0);
        tick();
        for (int k = 0; k < len; k++) begin
            wl = (lateLen >= 0) ? 8'(lateLen) : 8'($urandom_range(0, 255));
            applyStimulus(4'($urandom_range(0, 15)) | gexp, wl, evs[k]);
            tick();
            if (k < len - 1) begin
                checkOutput("done_low_in_count", done, 0);
                checkOutput("grant_held_in_count", grant, gexp);
                checkOutput("count_out_holds", count_out, lastCount);
            end
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("grant_in_report", grant, gexp);
        checkOutput("count_out_result", count_out, expCount);
        checkOutput("overflow_result", overflow, expOvf);
        lastCount = expCount;
        lastOvf   = expOvf;
        ptrModel  = (w + 1) % 4;

        applyStimulus(keepReq ? reqVal : 4'b0000, 8'(len), 1'b0);
        tick();
        checkOutput("done_single_cycle", done, 0);
        checkOutput("grant_released", grant, 0);
        checkOutput("busy_released", busy, 0);
        checkOutput("count_out_after_report", count_out, lastCount);
    endtask

    // nCount < 0 drops the request during CLEAR, otherwise after nCount samples.
    task automatic runAbort(input logic [3:0] reqVal, input int len, input int nCount);
        int         w;
        logic [3:0] gexp;
        logic       sawDone;
        w    = pickWinner(reqVal);
        gexp = onehot(w);
        applyStimulus(reqVal, 8'(len), 1'b0);
        tick();
        checkOutput("abort_grant", grant, gexp);
        if (nCount >= 0) begin
            tick();
            for (int k = 0; k < nCount; k++) begin
                applyStimulus(reqVal, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                tick();
            end
        end
        applyStimulus(reqVal & ~gexp, 8'(len), 1'b1);
        tick();
        checkOutput("abort_grant_low", grant, 0);
        checkOutput("abort_busy_low", busy, 0);
        checkOutput("abort_done_low", done, 0);
        checkOutput("abort_count_kept", count_out, lastCount);
        checkOutput("abort_ovf_kept", overflow, lastOvf);
        ptrModel = (w + 1) % 4;
        applyStimulus(4'b0000, 8'd0, 1'b0);
        sawDone = 1'b0;
        repeat (len + 3) begin
            tick();
            if (done) sawDone = 1'b1;
        end
        checkOutput("abort_never_reports", sawDone, 0);
    endtask

    initial begin
        logic sawDone;
        int   rl;
        int   nc;
        logic [3:0] rr;

        applyStimulus(4'b0000, 8'd0, 1'b0);
        reset = 1'b0;
        repeat (2) tick();
        checkOutput("reset_grant", grant, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_count_out", count_out, 0);
        checkOutput("reset_overflow", overflow, 0);
        reset = 1'b1;
        tick();

        $display("[TB] round-robin over 1011");
        fillEvents(0, 1);
        for (int n = 0; n < 4; n++) runWindow(4'b1011, 1, 1, 1'b1);
        applyStimulus(4'b0000, 8'd0, 1'b0);
        tick();

        $display("[TB] single window");
        evs[0] = 1'b1; evs[1] = 1'b0; evs[2] = 1'b1; evs[3] = 1'b1; evs[4] = 1'b0;
        runWindow(4'b0010, 5, -1, 1'b0);

        $display("[TB] wrap then quiet window");
        fillEvents(1, 20);
        runWindow(4'b0001, 20, -1, 1'b0);
        fillEvents(2, 2);
        runWindow(4'b0100, 2, -1, 1'b0);

        $display("[TB] zero length and abort");
        runWindow(4'b1000, 0, -1, 1'b0);
        fillEvents(1, 4);
        runWindow(4'b0010, 4, -1, 1'b0);
        runAbort(4'b0110, 6, 2);
        runAbort(4'b0001, 4, -1);

        $display("[TB] late window_len change");
        fillEvents(1, 3);
        runWindow(4'b0100, 3, 9, 1'b0);

        $display("[TB] reset mid-count");
        applyStimulus(4'b0001, 8'd10, 1'b0);
        tick();
        tick();
        applyStimulus(4'b0001, 8'd10, 1'b1);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("midcount_reset_grant", grant, 0);
        checkOutput("midcount_reset_busy", busy, 0);
        checkOutput("midcount_reset_count", count_out, 0);
        checkOutput("midcount_reset_ovf", overflow, 0);
        checkOutput("midcount_reset_done", done, 0);
        reset = 1'b1;
        applyStimulus(4'b0000, 8'd0, 1'b0);
        ptrModel  = 0;
        lastCount = '0;
        lastOvf   = 1'b0;
        sawDone   = 1'b0;
        repeat (12) begin
            tick();
            if (done) sawDone = 1'b1;
        end
        checkOutput("discarded_window_silent", sawDone, 0);
        fillEvents(0, 3);
        runWindow(4'b1111, 3, -1, 1'b0);

        $display("[TB] randomized windows");
        for (int n = 0; n < 14; n++) begin
            rr = 4'($urandom_range(1, 15));
            rl = int'($urandom_range(0, 24));
            fillEvents(0, rl);
            if (rl >= 2 && $urandom_range(0, 3) == 0) begin
                nc = int'($urandom_range(0, rl - 1)) - 1;
                runAbort(rr, rl, nc);
            end else begin
                runWindow(rr, rl, -1, 1'($urandom_range(0, 1)));
                applyStimulus(4'b0000, 8'd0, 1'b0);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
